// File: rtl/tt_um_uabc_vap2024.sv
// 8-bit accumulator calculator tile: one ALU operation per rising edge of the strobe on uio_in[3].
// Optional build macro SATURATE_EN clamps ADD on carry to 8'hFF and SUB on borrow to 8'h00.
module tt_um_uabc_vap2024 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_SHL  = 3'd6,
        OP_SHR  = 3'd7
    } op_e;

`ifdef SATURATE_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    function automatic logic [7:0] saturate(input logic [7:0] raw, input logic hit,
                                            input logic [7:0] limit);
        return (SAT_ON && hit) ? limit : raw;
    endfunction

    logic [7:0] acc_q, acc_d;
    logic       c_q, c_d;
    logic       v_q, v_d;
    logic       stb_prev_q, stb_prev_d;
    logic       stb, exec;
    op_e        op;
    logic [8:0] sum9, diff9;
    logic       unused_uio;

    assign stb        = uio_in[3];
    assign op         = op_e'(uio_in[2:0]);
    assign exec       = ena && stb && !stb_prev_q;
    assign sum9       = {1'b0, acc_q} + {1'b0, ui_in};
    assign diff9      = {1'b0, acc_q} - {1'b0, ui_in};
    assign unused_uio = &{1'b0, uio_in[7:4]};

    always_comb begin
        acc_d      = acc_q;
        c_d        = c_q;
        v_d        = v_q;
        stb_prev_d = ena ? stb : stb_prev_q;
        if (exec) begin
            c_d = 1'b0;
            v_d = 1'b0;
            case (op)
                OP_LOAD: acc_d = ui_in;
                OP_ADD: begin
                    c_d   = sum9[8];
                    v_d   = (acc_q[7] == ui_in[7]) && (sum9[7] != acc_q[7]);
                    acc_d = saturate(sum9[7:0], sum9[8], 8'hFF);
                end
                OP_SUB: begin
                    // Bit 8 of the 9-bit difference is the unsigned borrow (A < B).
                    c_d   = diff9[8];
                    v_d   = (acc_q[7] != ui_in[7]) && (diff9[7] != acc_q[7]);
                    acc_d = saturate(diff9[7:0], diff9[8], 8'h00);
                end
                OP_AND: acc_d = acc_q & ui_in;
                OP_OR:  acc_d = acc_q | ui_in;
                OP_XOR: acc_d = acc_q ^ ui_in;
                OP_SHL: begin
                    acc_d = {acc_q[6:0], 1'b0};
                    c_d   = acc_q[7];
                end
                OP_SHR: begin
                    acc_d = {1'b0, acc_q[7:1]};
                    c_d   = acc_q[0];
                end
                default: acc_d = acc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            acc_q      <= 8'h00;
            c_q        <= 1'b0;
            v_q        <= 1'b0;
            stb_prev_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            c_q        <= c_d;
            v_q        <= v_d;
            stb_prev_q <= stb_prev_d;
        end
    end

    assign uo_out  = acc_q;
    assign uio_out = {v_q, c_q, acc_q[7], (acc_q == 8'h00), 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_uabc_vap2024.sv
// Self-checking bench for tt_um_uabc_vap2024: directed scenarios plus randomized traffic
// compared against an integer-arithmetic reference model.
module tb_tt_um_uabc_vap2024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int n_cmp = 0;
    int n_bad = 0;

    int m_acc = 0;
    bit m_c = 0, m_v = 0, m_prev = 0;

    tt_um_uabc_vap2024 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int to_signed(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    task automatic model_exec(input int opc, input int b);
        int a, r, sr;
        bit sat;
        a   = m_acc;
        sat = 0;
`ifdef SATURATE_EN
        sat = 1;
`endif
        m_c = 0;
        m_v = 0;
        case (opc)
            0: r = b;
            1: begin
                r   = a + b;
                sr  = to_signed(a) + to_signed(b);
                m_c = (r > 255);
                m_v = (sr > 127) || (sr < -128);
                r   = (sat && m_c) ? 255 : r % 256;
            end
            2: begin
                r   = a - b;
                sr  = to_signed(a) - to_signed(b);
                m_c = (a < b);
                m_v = (sr > 127) || (sr < -128);
                r   = (sat && m_c) ? 0 : (r + 256) % 256;
            end
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: begin
                r   = (a * 2) % 256;
                m_c = (a >= 128);
            end
            default: begin
                r   = a / 2;
                m_c = (a % 2) == 1;
            end
        endcase
        m_acc = r;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
    task automatic cycle(input bit rst, input bit en, input bit stb, input int opc, input int b);
        logic [7:0] exp_flags;
        rst_n  = rst;
        ena    = en;
        ui_in  = 8'(b);
        uio_in = {4'($urandom_range(0, 15)), stb, 3'(opc)};
        @(posedge clk);
        if (rst) begin
            m_acc = 0; m_c = 0; m_v = 0; m_prev = 0;
        end else if (en) begin
            if (stb && !m_prev) model_exec(opc, b);
            m_prev = stb;
        end
        #1;
        exp_flags = 8'(m_v * 128 + m_c * 64 + (m_acc >= 128) * 32 + (m_acc == 0) * 16);
        chk("acc", uo_out, 8'(m_acc));
        chk("flags", uio_out, exp_flags);
        chk("oe", uio_oe, 8'hF0);
    endtask

    task automatic do_op(input int opc, input int b);
        cycle(0, 1, 0, opc, b);
        cycle(0, 1, 1, opc, b);
    endtask

    initial begin
        // Reset for two clocks with STB toggling
        cycle(1, 1, 1, 1, 8'h55);
        cycle(1, 1, 0, 1, 8'h55);
        chk("rst_acc", uo_out, 8'h00);
        chk("rst_uio", uio_out, 8'h10);
        chk("rst_oe", uio_oe, 8'hF0);

        do_op(0, 8'h7F);
        do_op(1, 8'h01);
        chk("add_ovf_acc", uo_out, 8'h80);
        chk("add_ovf_flg", uio_out, 8'hA0);
        do_op(1, 8'h80);
`ifdef SATURATE_EN
        chk("add_wrap_acc", uo_out, 8'hFF);
        chk("add_wrap_flg", uio_out, 8'hE0);
`else
        chk("add_wrap_acc", uo_out, 8'h00);
        chk("add_wrap_flg", uio_out, 8'hD0);
`endif

        do_op(0, 8'h05);
        do_op(2, 8'h07);
`ifdef SATURATE_EN
        chk("sub_brw_acc", uo_out, 8'h00);
        chk("sub_brw_flg", uio_out, 8'h50);
`else
        chk("sub_brw_acc", uo_out, 8'hFE);
        chk("sub_brw_flg", uio_out, 8'h60);
`endif

        do_op(0, 8'h81);
        do_op(6, 8'h00);
        chk("shl_acc", uo_out, 8'h02);
        chk("shl_flg", uio_out, 8'h40);
        do_op(7, 8'hAA);
        chk("shr_acc", uo_out, 8'h01);
        chk("shr_flg", uio_out, 8'h00);
        do_op(5, 8'hFF);
        chk("xor_acc", uo_out, 8'hFE);
        chk("xor_flg", uio_out, 8'h20);

        // STB held high executes only once
        do_op(0, 8'h00);
        do_op(1, 8'h01);
        for (int i = 0; i < 5; i++) cycle(0, 1, 1, 1, 8'h01);
        chk("hold_acc", uo_out, 8'h01);

        // Strobe edge while disabled, then enable with STB still high
        cycle(0, 0, 0, 1, 8'h10);
        cycle(0, 0, 1, 1, 8'h10);
        cycle(0, 0, 1, 1, 8'h10);
        chk("ena0_acc", uo_out, 8'h01);
        cycle(0, 1, 1, 1, 8'h10);
        cycle(0, 1, 1, 1, 8'h10);
        chk("ena_rise_acc", uo_out, 8'h01);

        // Reset coincident with an ADD strobe
        do_op(0, 8'h3C);
        cycle(0, 1, 0, 1, 8'h05);
        cycle(1, 1, 1, 1, 8'h05);
        chk("rst_stb_acc", uo_out, 8'h00);
        chk("rst_stb_flg", uio_out, 8'h10);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0),
                  $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tt_um_uabc_vap2024.md
Name: tt_um_uabc_vap2024

Overview:
- 8-bit accumulator calculator packaged as a TinyTapeout user tile; standard tile pinout.
- Each rising edge of a strobe input applies one operation between the accumulator and the 8-bit operand on ui_in.
- Accumulator drives uo_out; status flags drive the upper uio pins.

Parameters:
- None. Widths are fixed at 8 bits by the tile pinout.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  reset; synchronous, active-high (1 = reset), name kept for harness compatibility.
- ena  input  1  tile enable; 0 = strobes ignored, all state held.
- ui_in  input  8  operand B.
- uio_in  input  8  [2:0] opcode, [3] strobe STB, [7:4] unused.
- uo_out  output  8  accumulator ACC.
- uio_out  output  8  [7] V, [6] C, [5] N, [4] Z; [3:0] driven 0.
- uio_oe  output  8  constant 8'hF0 ([7:4] outputs, [3:0] inputs).

Behaviour:
- Reset (rst_n=1 at a clock edge): ACC=0, C=0, V=0, STB_prev=0; hence uo_out=0, uio_out=8'h10 (Z=1).
- Reset has priority over everything, including a strobe in the same cycle.
- Reset mid-sequence discards the accumulator with no partial update.
- STB_prev register samples STB every clock while ena=1, and holds while ena=0.
- Execute condition: ena=1 and STB=1 and STB_prev=0 at a clock edge. Exactly one operation per rising edge of STB.
- Holding STB high executes nothing further. A strobe rising while ena=0 is not executed later.
- Latency: ACC, C and V update at the same edge that detects the strobe; new values appear on outputs immediately after that edge.
- Opcode and B are sampled at the execute edge only.
- Opcodes (A = current ACC):
  - 000 LOAD: ACC=B; C=0, V=0.
  - 001 ADD: ACC=(A+B) mod 256; C=carry out of bit 7; V=signed overflow (A[7]==B[7] and result[7]!=A[7]).
  - 010 SUB: ACC=(A-B) mod 256; C=1 iff A<B unsigned (borrow); V=signed overflow (A[7]!=B[7] and result[7]!=A[7]).
  - 011 AND, 100 OR, 101 XOR: bitwise with B; C=0, V=0.
  - 110 SHL: ACC={A[6:0],0}; C=A[7]; V=0; B ignored.
  - 111 SHR (logical): ACC={0,A[7:1]}; C=A[0]; V=0; B ignored.
- Z=(ACC==0) and N=ACC[7] are combinational from ACC. C and V are registered and change only on an execute or reset.
- Without an execute, ACC, C and V hold indefinitely.
- uio_in[7:4] has no effect.

Optional Feature:
- Macro SATURATE_EN.
- Defined: ADD whose unsigned carry is set yields ACC=8'hFF; SUB with borrow yields ACC=8'h00. C and V are computed exactly as in the unsaturated case from the raw result; Z/N follow the saturated ACC. All other opcodes are unchanged.
- Undefined: ADD/SUB wrap modulo 256 as specified above.

Test Plan:
- Reset: assert rst_n=1 for 2 clocks with STB toggling -> uo_out=8'h00, uio_out=8'h10, uio_oe=8'hF0.
- LOAD 8'h7F, then ADD 8'h01 -> uo_out=8'h80, V=1, N=1, C=0, Z=0; then ADD 8'h80 -> uo_out=8'h00, C=1, V=1, Z=1.
- LOAD 8'h05, SUB 8'h07 -> uo_out=8'hFE, C=1, N=1, V=0. With SATURATE_EN -> uo_out=8'h00, C=1, Z=1.
- LOAD 8'h81, SHL -> 8'h02, C=1; SHR -> 8'h01, C=0; XOR 8'hFF -> 8'hFE, C=0, V=0.
- Hold STB high 5 cycles with ADD 8'h01 from 8'h00 -> uo_out=8'h01 (single execute). Strobe rising while ena=0 -> no change; raising ena with STB still high -> no execute.
- LOAD 8'h3C, then assert rst_n=1 in the same cycle as an ADD strobe -> uo_out=8'h00, C=0, V=0.
